// File: rtl/frame_pair_streamer_if.sv
// Frame-buffer read port and paired-pixel output stream of frame_pair_streamer.
// The streamer drives through 'master'; a frame-buffer/consumer pair sits on 'slave'.
interface frame_pair_streamer_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = 17
);
    logic                   mem_rd_en;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [PIXEL_WIDTH-1:0] mem_rdata_curr;
    logic [PIXEL_WIDTH-1:0] mem_rdata_prev;
    logic [PIXEL_WIDTH-1:0] pixel_curr;
    logic [PIXEL_WIDTH-1:0] pixel_prev;
    logic                   pixel_valid;
    logic [9:0]             pixel_x_out;
    logic [8:0]             pixel_y_out;
    logic                   frame_start;
    logic                   frame_end;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata_curr, mem_rdata_prev,
        output pixel_curr, pixel_prev, pixel_valid,
        output pixel_x_out, pixel_y_out, frame_start, frame_end
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata_curr, mem_rdata_prev,
        input  pixel_curr, pixel_prev, pixel_valid,
        input  pixel_x_out, pixel_y_out, frame_start, frame_end
    );
endinterface

// File: rtl/frame_pair_streamer.sv
// Raster-order reader of the current/previous frame buffers over one shared address,
// emitting registered pixel pairs with coordinates, line blanking and a done pulse.
//
//   state   | meaning
//   IDLE    | waiting for start, address parked at 0
//   READ    | one read per cycle, raster counters advance
//   BLANK   | H_BLANK idle cycles between lines
//   DRAIN   | RD_LATENCY+1 cycles while the last reads leave the pipeline
//   DONE    | one-cycle done pulse
module frame_pair_streamer #(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int PIXEL_WIDTH = 8,
    parameter int RD_LATENCY  = 1,
    parameter int H_BLANK     = 0,
    parameter int ADDR_WIDTH  = $clog2(WIDTH*HEIGHT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    frame_pair_streamer_if.master bus
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_BLANK, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic       valid;
        logic       fs;
        logic       fe;
        logic [9:0] x;
        logic [8:0] y;
    } tag_t;

    state_t                 state_q, state_d;
    logic [9:0]             x_q, x_d;
    logic [8:0]             y_q, y_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [7:0]             timer_q, timer_d;
    logic                   rd_en;
    logic                   last_col, last_row;
    tag_t                   tag_in;
    tag_t                   pipe_q [RD_LATENCY];
    tag_t                   tail;

    logic [PIXEL_WIDTH-1:0] curr_q, prev_q;
    logic [9:0]             px_q;
    logic [8:0]             py_q;
    logic                   valid_q, fs_q, fe_q;

    assign last_col = (x_q == 10'(WIDTH - 1));
    assign last_row = (y_q == 9'(HEIGHT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        timer_d = timer_q;
        rd_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                x_d    = '0;
                y_d    = '0;
                addr_d = '0;
                if (start) state_d = S_READ;
            end
            S_READ: begin
                rd_en = 1'b1;
                if (last_col && last_row) begin
                    // park the address so no read can run past the last pixel
                    state_d = S_DRAIN;
                    timer_d = 8'(RD_LATENCY);
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                end else if (last_col) begin
                    x_d    = '0;
                    y_d    = y_q + 9'd1;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (H_BLANK > 0) begin
                        state_d = S_BLANK;
                        timer_d = 8'(H_BLANK - 1);
                    end
                end else begin
                    x_d    = x_q + 10'd1;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            S_BLANK: begin
                if (timer_q == 8'd0) state_d = S_READ;
                else                 timer_d = timer_q - 8'd1;
            end
            S_DRAIN: begin
                if (timer_q == 8'd0) state_d = S_DONE;
                else                 timer_d = timer_q - 8'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = rd_en;
        tag_in.fs    = rd_en && (x_q == 10'd0) && (y_q == 9'd0);
        tag_in.fe    = rd_en && last_col && last_row;
        tag_in.x     = x_q;
        tag_in.y     = y_q;
    end

    // coordinate/flag delay line matched to the frame-buffer read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= tag_in;
            for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tail = pipe_q[RD_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curr_q  <= '0;
            prev_q  <= '0;
            px_q    <= '0;
            py_q    <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            valid_q <= tail.valid;
            fs_q    <= tail.valid & tail.fs;
            fe_q    <= tail.valid & tail.fe;
            if (tail.valid) begin
                curr_q <= bus.mem_rdata_curr;
                prev_q <= bus.mem_rdata_prev;
                px_q   <= tail.x;
                py_q   <= tail.y;
            end
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);
    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_addr    = addr_q;
    assign bus.pixel_curr  = curr_q;
    assign bus.pixel_prev  = prev_q;
    assign bus.pixel_valid = valid_q;
    assign bus.pixel_x_out = px_q;
    assign bus.pixel_y_out = py_q;
    assign bus.frame_start = fs_q;
    assign bus.frame_end   = fe_q;

endmodule

// File: tb/tb_frame_pair_streamer.sv
// Scoreboard bench for frame_pair_streamer on an 8x4 frame: three instances cover
// no blanking, H_BLANK=2 and RD_LATENCY=3; one negedge monitor checks every output.
module tb_frame_pair_streamer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int PW = 8;
    localparam int AW = 5;
    localparam int N  = 3;
    localparam int LAT_T [N] = '{1, 1, 3};
    localparam int HB_T  [N] = '{0, 2, 0};

    typedef struct { int cyc; int addr; } rd_t;
    typedef struct { int cyc; int curr; int prev; int x; int y; int fs; int fe; } px_t;
    typedef struct { int base; int cyc; } dn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [N-1:0] start_v = '0;
    logic [N-1:0] busy_w, done_w, rd_w, pv_w, fs_w, fe_w;
    logic [AW-1:0] addr_w [N];
    logic [PW-1:0] pc_w [N];
    logic [PW-1:0] pp_w [N];
    logic [9:0]    px_w [N];
    logic [8:0]    py_w [N];

    rd_t rd_q [N][$];
    px_t px_q [N][$];
    dn_t dn_q [N][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = LAT_T[g];
        logic [AW-1:0] apipe [4];

        frame_pair_streamer_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

        frame_pair_streamer #(
            .WIDTH(W), .HEIGHT(H), .PIXEL_WIDTH(PW),
            .RD_LATENCY(L), .H_BLANK(HB_T[g]), .ADDR_WIDTH(AW)
        ) dut (
            .clk(clk), .rst_n(rst_n), .start(start_v[g]),
            .busy(busy_w[g]), .done(done_w[g]), .bus(bus)
        );

        // frame buffers: curr returns the address, prev returns address+100
        always @(posedge clk) begin
            apipe[0] <= bus.mem_addr;
            for (int k = 1; k < 4; k++) apipe[k] <= apipe[k-1];
        end
        assign bus.mem_rdata_curr = PW'(apipe[L-1]);
        assign bus.mem_rdata_prev = PW'(apipe[L-1]) + PW'(100);

        assign rd_w[g]   = bus.mem_rd_en;
        assign addr_w[g] = bus.mem_addr;
        assign pv_w[g]   = bus.pixel_valid;
        assign pc_w[g]   = bus.pixel_curr;
        assign pp_w[g]   = bus.pixel_prev;
        assign px_w[g]   = bus.pixel_x_out;
        assign py_w[g]   = bus.pixel_y_out;
        assign fs_w[g]   = bus.frame_start;
        assign fe_w[g]   = bus.frame_end;
    end

    function automatic int done_rel(int i);
        return 1 + (H-1)*(W+HB_T[i]) + (W-1) + LAT_T[i] + 2;
    endfunction

    // start sampled at the posedge after negedge 'c': read k at c+1+y*(W+HB)+x
    task automatic push_frame(int i, int c);
        int k, r;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                k = y*W + x;
                r = 1 + y*(W+HB_T[i]) + x;
                rd_q[i].push_back('{cyc: c+r, addr: k});
                px_q[i].push_back('{cyc: c+r+LAT_T[i]+1, curr: k, prev: k+100,
                                    x: x, y: y, fs: int'(k == 0), fe: int'(k == W*H-1)});
            end
        end
        dn_q[i].push_back('{base: c, cyc: c + done_rel(i)});
    endtask

    task automatic flush_all();
        for (int i = 0; i < N; i++) begin
            rd_q[i].delete();
            px_q[i].delete();
            dn_q[i].delete();
        end
    endtask

    task automatic run_frame(int i);
        int c;
        @(negedge clk);
        c = cyc;
        start_v[i] = 1'b1;
        push_frame(i, c);
        @(negedge clk);
        start_v[i] = 1'b0;
        repeat (done_rel(i) + 4) @(negedge clk);
    endtask

    // monitor: pops expectations whenever the DUT presents a read, pixel or done
    always @(negedge clk) begin
        rd_t  re;
        px_t  pe;
        dn_t  de;
        logic eb;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                n_tests++;
                if ({busy_w[i], done_w[i], rd_w[i], addr_w[i], pv_w[i], pc_w[i], pp_w[i],
                     px_w[i], py_w[i], fs_w[i], fe_w[i]} != '0) begin
                    n_fail++;
                    $display("FAIL reset_zero inst%0d: busy=%b done=%b rd=%b addr=%0d pv=%b curr=%0d prev=%0d x=%0d y=%0d fs=%b fe=%b, required all 0",
                             i, busy_w[i], done_w[i], rd_w[i], addr_w[i], pv_w[i], pc_w[i], pp_w[i],
                             px_w[i], py_w[i], fs_w[i], fe_w[i]);
                end
            end else begin
                eb = (dn_q[i].size() != 0) && (dn_q[i][0].base < cyc) && (cyc <= dn_q[i][0].cyc);
                n_tests++;
                if (busy_w[i] !== eb) begin
                    n_fail++;
                    $display("FAIL busy inst%0d cyc %0d: got %b required %b", i, cyc, busy_w[i], eb);
                end

                if (rd_w[i] === 1'b1) begin
                    n_tests++;
                    if (rd_q[i].size() == 0) begin
                        n_fail++;
                        $display("FAIL rd_unexpected inst%0d cyc %0d: addr %0d, required no read", i, cyc, addr_w[i]);
                    end else begin
                        re = rd_q[i].pop_front();
                        if (re.cyc != cyc || re.addr != int'(addr_w[i])) begin
                            n_fail++;
                            $display("FAIL rd inst%0d: got cyc %0d addr %0d required cyc %0d addr %0d",
                                     i, cyc, addr_w[i], re.cyc, re.addr);
                        end
                    end
                end else if (rd_q[i].size() != 0 && rd_q[i][0].cyc <= cyc) begin
                    re = rd_q[i].pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_missing inst%0d: no read at cyc %0d, required addr %0d", i, cyc, re.addr);
                end

                if (pv_w[i] === 1'b1) begin
                    n_tests++;
                    if (px_q[i].size() == 0) begin
                        n_fail++;
                        $display("FAIL px_unexpected inst%0d cyc %0d: curr %0d, required no pixel", i, cyc, pc_w[i]);
                    end else begin
                        pe = px_q[i].pop_front();
                        if (pe.cyc != cyc || pe.curr != int'(pc_w[i]) || pe.prev != int'(pp_w[i]) ||
                            pe.x != int'(px_w[i]) || pe.y != int'(py_w[i]) ||
                            pe.fs != int'(fs_w[i]) || pe.fe != int'(fe_w[i])) begin
                            n_fail++;
                            $display("FAIL pixel inst%0d: got cyc %0d c=%0d p=%0d (%0d,%0d) fs=%b fe=%b required cyc %0d c=%0d p=%0d (%0d,%0d) fs=%0d fe=%0d",
                                     i, cyc, pc_w[i], pp_w[i], px_w[i], py_w[i], fs_w[i], fe_w[i],
                                     pe.cyc, pe.curr, pe.prev, pe.x, pe.y, pe.fs, pe.fe);
                        end
                    end
                end else begin
                    if (fs_w[i] !== 1'b0 || fe_w[i] !== 1'b0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL flags_idle inst%0d cyc %0d: fs=%b fe=%b required 0 0", i, cyc, fs_w[i], fe_w[i]);
                    end
                    if (px_q[i].size() != 0 && px_q[i][0].cyc <= cyc) begin
                        pe = px_q[i].pop_front();
                        n_tests++;
                        n_fail++;
                        $display("FAIL px_missing inst%0d: no pixel at cyc %0d, required curr %0d", i, cyc, pe.curr);
                    end
                end

                if (done_w[i] === 1'b1) begin
                    n_tests++;
                    if (dn_q[i].size() == 0) begin
                        n_fail++;
                        $display("FAIL done_unexpected inst%0d cyc %0d: done=1 required 0", i, cyc);
                    end else begin
                        de = dn_q[i].pop_front();
                        if (de.cyc != cyc) begin
                            n_fail++;
                            $display("FAIL done inst%0d: got cyc %0d required cyc %0d", i, cyc, de.cyc);
                        end
                    end
                end else if (dn_q[i].size() != 0 && dn_q[i][0].cyc <= cyc) begin
                    de = dn_q[i].pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL done_missing inst%0d: no done at cyc %0d required %0d", i, cyc, de.cyc);
                end
            end
        end
    end

    initial begin
        int c, d;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // no blanking, latency 1
        run_frame(0);

        // H_BLANK=2 with a start pulse during READ that must be ignored
        @(negedge clk);
        c = cyc;
        start_v[1] = 1'b1;
        push_frame(1, c);
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (8) @(negedge clk);
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (done_rel(1) + 6) @(negedge clk);

        // read latency 3
        run_frame(2);

        // start held: second frame reads begin two cycles after done
        @(negedge clk);
        c = cyc;
        d = done_rel(0);
        start_v[0] = 1'b1;
        push_frame(0, c);
        push_frame(0, c + d + 1);
        repeat (d + 3) @(negedge clk);
        start_v[0] = 1'b0;
        repeat (d + 6) @(negedge clk);

        // reset around pixel 10, then a clean restart from address 0
        @(negedge clk);
        c = cyc;
        start_v[0] = 1'b1;
        push_frame(0, c);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        flush_all();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run_frame(0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
